// File: rtl/traffic_lamp_driver_if.sv
// Controller-side light codes in, lamp drive and fault status out.
interface traffic_lamp_driver_if;
    logic       tick;
    logic [1:0] ns_light;
    logic [1:0] ew_light;
    logic       fault_clr;
    logic [2:0] ns_lamp;
    logic [2:0] ew_lamp;
    logic       fault;
    logic [1:0] fault_code;

    modport master (
        output tick, ns_light, ew_light, fault_clr,
        input  ns_lamp, ew_lamp, fault, fault_code
    );

    modport slave (
        input  tick, ns_light, ew_light, fault_clr,
        output ns_lamp, ew_lamp, fault, fault_code
    );
endinterface

// File: rtl/traffic_lamp_driver.sv
// Safety lamp driver: registers the controller's light codes onto lamps and
// traps illegal, conflicting or badly sequenced codes into a flashing-red fault.
module traffic_lamp_driver #(
    parameter int unsigned MIN_YELLOW    = 2,
    parameter int unsigned STARTUP_TICKS = 3
) (
    input logic                  clk,
    input logic                  rst,
    traffic_lamp_driver_if.slave bus
);

    localparam logic [1:0] ST_STARTUP = 2'd0;
    localparam logic [1:0] ST_NORMAL  = 2'd1;
    localparam logic [1:0] ST_FAULT   = 2'd2;

    localparam logic [1:0] L_RED     = 2'b00;
    localparam logic [1:0] L_GREEN   = 2'b01;
    localparam logic [1:0] L_YELLOW  = 2'b10;
    localparam logic [1:0] L_ILLEGAL = 2'b11;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_ILLEGAL  = 2'b01;
    localparam logic [1:0] FC_CONFLICT = 2'b10;
    localparam logic [1:0] FC_SEQUENCE = 2'b11;

    localparam int unsigned   SU_W    = (STARTUP_TICKS > 1) ? $clog2(STARTUP_TICKS + 1) : 1;
    localparam logic [SU_W-1:0] SU_LOAD = SU_W'(STARTUP_TICKS);

    logic [1:0]      state;
    logic [SU_W-1:0] su_cnt;
    logic [1:0]      prev_ns;
    logic [1:0]      prev_ew;
    logic [3:0]      ycnt_ns;
    logic [3:0]      ycnt_ew;
    logic            flash;
    logic [2:0]      ns_lamp_q;
    logic [2:0]      ew_lamp_q;
    logic            fault_q;
    logic [1:0]      fault_code_q;

    logic            illegal;
    logic            conflict;
    logic            seq_err;
    logic [1:0]      det_code;
    logic            flash_next;
    logic            clear_ok;

    function automatic logic [2:0] lamp_decode(input logic [1:0] code);
        case (code)
            L_GREEN:  return LAMP_GREEN;
            L_YELLOW: return LAMP_YELLOW;
            default:  return LAMP_RED;
        endcase
    endfunction

    function automatic logic seq_bad(input logic [1:0] p, input logic [1:0] c,
                                     input logic [3:0] ycnt);
        logic short_yellow;
        short_yellow = ({28'd0, ycnt} < MIN_YELLOW);
        return ((p == L_GREEN)  && (c == L_RED))    ||
               ((p == L_YELLOW) && (c == L_GREEN))  ||
               ((p == L_RED)    && (c == L_YELLOW)) ||
               ((p == L_YELLOW) && (c == L_RED) && short_yellow);
    endfunction

    // Counts only ticks seen while yellow was already held in the previous
    // cycle, so ticks coinciding with entry or exit are never counted.
    function automatic logic [3:0] ycnt_next(input logic [1:0] p, input logic [1:0] c,
                                             input logic [3:0] ycnt, input logic tick);
        if (c != L_YELLOW)
            return ycnt;
        else if (p != L_YELLOW)
            return '0;
        else if (tick && (ycnt != 4'hF))
            return ycnt + 4'd1;
        else
            return ycnt;
    endfunction

    always_comb begin
        illegal    = (bus.ns_light == L_ILLEGAL) || (bus.ew_light == L_ILLEGAL);
        conflict   = (bus.ns_light != L_RED) && (bus.ew_light != L_RED);
        seq_err    = seq_bad(prev_ns, bus.ns_light, ycnt_ns) ||
                     seq_bad(prev_ew, bus.ew_light, ycnt_ew);
        det_code   = FC_NONE;
        if (illegal)
            det_code = FC_ILLEGAL;
        else if (conflict)
            det_code = FC_CONFLICT;
        else if (seq_err)
            det_code = FC_SEQUENCE;
        flash_next = bus.tick ? ~flash : flash;
        clear_ok   = bus.fault_clr && (bus.ns_light == L_RED) && (bus.ew_light == L_RED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_STARTUP;
            su_cnt       <= SU_LOAD;
            prev_ns      <= L_RED;
            prev_ew      <= L_RED;
            ycnt_ns      <= '0;
            ycnt_ew      <= '0;
            flash        <= 1'b1;
            ns_lamp_q    <= LAMP_RED;
            ew_lamp_q    <= LAMP_RED;
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
        end else begin
            prev_ns <= bus.ns_light;
            prev_ew <= bus.ew_light;
            ycnt_ns <= ycnt_next(prev_ns, bus.ns_light, ycnt_ns, bus.tick);
            ycnt_ew <= ycnt_next(prev_ew, bus.ew_light, ycnt_ew, bus.tick);

            case (state)
                ST_STARTUP: begin
                    ns_lamp_q <= LAMP_RED;
                    ew_lamp_q <= LAMP_RED;
                    if (bus.tick) begin
                        if (su_cnt <= SU_W'(1))
                            state <= ST_NORMAL;
                        else
                            su_cnt <= su_cnt - SU_W'(1);
                    end
                end

                ST_NORMAL: begin
                    // A detected fault blanks to red on the same edge, so the
                    // offending code is never decoded onto the lamps.
                    if (det_code != FC_NONE) begin
                        state        <= ST_FAULT;
                        fault_q      <= 1'b1;
                        fault_code_q <= det_code;
                        flash        <= 1'b1;
                        ns_lamp_q    <= LAMP_RED;
                        ew_lamp_q    <= LAMP_RED;
                    end else begin
                        ns_lamp_q <= lamp_decode(bus.ns_light);
                        ew_lamp_q <= lamp_decode(bus.ew_light);
                    end
                end

                ST_FAULT: begin
                    if (clear_ok) begin
                        state        <= ST_STARTUP;
                        su_cnt       <= SU_LOAD;
                        fault_q      <= 1'b0;
                        fault_code_q <= FC_NONE;
                        ns_lamp_q    <= LAMP_RED;
                        ew_lamp_q    <= LAMP_RED;
                    end else begin
                        flash     <= flash_next;
                        ns_lamp_q <= {flash_next, 2'b00};
                        ew_lamp_q <= {flash_next, 2'b00};
                    end
                end

                default: begin
                    state     <= ST_STARTUP;
                    su_cnt    <= SU_LOAD;
                    ns_lamp_q <= LAMP_RED;
                    ew_lamp_q <= LAMP_RED;
                end
            endcase
        end
    end

    assign bus.ns_lamp    = ns_lamp_q;
    assign bus.ew_lamp    = ew_lamp_q;
    assign bus.fault      = fault_q;
    assign bus.fault_code = fault_code_q;

endmodule
